// File: rtl/sprite_compositor_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_compositor_if
// Description : Bundle of pixel-stream, sprite-bank and VGA colour signals
//               exchanged between the sync/game logic (master) and the
//               sprite compositor (slave).
//               master drives : xCount, yCount, displayArea, frame_start,
//                               sprite_x/y/en/rgb, win, lose
//               slave drives  : VGA_R, VGA_G, VGA_B, collision
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_compositor_if #(
  parameter int unsigned NUM_SPRITES = 8
);
  logic [9:0]                 xCount;
  logic [9:0]                 yCount;
  logic                       displayArea;
  logic                       frame_start;
  logic [NUM_SPRITES*10-1:0]  sprite_x;
  logic [NUM_SPRITES*9-1:0]   sprite_y;
  logic [NUM_SPRITES-1:0]     sprite_en;
  logic [NUM_SPRITES*3-1:0]   sprite_rgb;
  logic                       win;
  logic                       lose;
  logic [7:0]                 VGA_R;
  logic [7:0]                 VGA_G;
  logic [7:0]                 VGA_B;
  logic [NUM_SPRITES-1:0]     collision;

  modport master (
    output xCount, yCount, displayArea, frame_start,
    output sprite_x, sprite_y, sprite_en, sprite_rgb, win, lose,
    input  VGA_R, VGA_G, VGA_B, collision
  );

  modport slave (
    input  xCount, yCount, displayArea, frame_start,
    input  sprite_x, sprite_y, sprite_en, sprite_rgb, win, lose,
    output VGA_R, VGA_G, VGA_B, collision
  );
endinterface
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : sprite_compositor
// Description : 3-stage pipelined VGA pixel compositor. Draws up to
//               NUM_SPRITES square sprites (lowest index on top) over an
//               optional coloured border, with win/lose colour overrides.
//               Sprite positions are banked on frame_start so objects never
//               tear, and per-sprite overlap flags are published per frame.
//               Ports : VGA_clk (pixel clock), reset (sync, active high),
//                       bus (sprite_compositor_if.slave): pixel coordinates,
//                       sprite descriptors, win/lose in; VGA_R/G/B and
//                       collision flags out. Latency xCount -> VGA_* is 3.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_compositor #(
  parameter int unsigned NUM_SPRITES = 8,
  parameter int unsigned SPRITE_W    = 10,
  parameter int unsigned SPRITE_H    = 10,
  parameter int unsigned BORDER      = 11,
  parameter logic [2:0]  BORDER_RGB  = 3'b001
) (
  input  logic               VGA_clk,
  input  logic               reset,
  sprite_compositor_if.slave bus
);

  localparam int unsigned N    = NUM_SPRITES;
  localparam logic [10:0] SW   = 11'(SPRITE_W);
  localparam logic [10:0] SH   = 11'(SPRITE_H);
  localparam logic [9:0]  B_LO = 10'(BORDER);
  localparam logic [9:0]  X_HI = 10'(640 - BORDER);
  localparam logic [9:0]  Y_HI = 10'(480 - BORDER);

  // Stage 1: registered pixel and flags
  logic [9:0]   x1_q, y1_q;
  logic         de1_q, win1_q, lose1_q;

  // Active sprite bank, reloaded only on frame_start
  logic [9:0]   bx_q   [N];
  logic [8:0]   by_q   [N];
  logic [2:0]   brgb_q [N];
  logic [N-1:0] ben_q;

  // Stage 2: registered hit results
  logic [N-1:0] hit2_q;
  logic         border2_q, de2_q, win2_q, lose2_q;

  // Stage 3: output colour and collision state
  logic [7:0]   r_q, g_q, b_q;
  logic [N-1:0] acc_q, coll_q;

  logic [N-1:0] hit_d;
  logic         border_d;
  logic [2:0]   pix_d;
  logic [N-1:0] set_d;
  logic [10:0]  px, py;

  // Widened to 11 bits so sprite x + width cannot wrap near 1023
  assign px = {1'b0, x1_q};
  assign py = {1'b0, y1_q};

  for (genvar i = 0; i < N; i++) begin : g_hit
    logic [10:0] sx, sy;
    assign sx = {1'b0, bx_q[i]};
    assign sy = {2'b00, by_q[i]};
    // Strict on both edges: the drawn area is (W-1) x (H-1)
    assign hit_d[i] = ben_q[i] && (px > sx) && (px < sx + SW)
                               && (py > sy) && (py < sy + SH);
  end

  if (BORDER == 0) begin : g_no_border
    assign border_d = 1'b0;
  end else begin : g_border
    assign border_d = (x1_q < B_LO) || (x1_q >= X_HI) ||
                      (y1_q < B_LO) || (y1_q >= Y_HI);
  end

  // Priority mux: walk from highest index down so the lowest hit wins
  always_comb begin
    pix_d = 3'b000;
    if (border2_q) pix_d = BORDER_RGB;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (hit2_q[i]) pix_d = brgb_q[i];
    end
    if (!de2_q) pix_d = 3'b000;
    // win/lose overrides are deliberately not gated by displayArea
    pix_d[2] = pix_d[2] | lose2_q;
    pix_d[1] = pix_d[1] | win2_q;
  end

  // h & (h-1) clears the lowest set bit, so it is non-zero iff two or more
  // sprites hit; every hitting sprite is then flagged as colliding.
  always_comb begin
    set_d = '0;
    if (de2_q && (|(hit2_q & (hit2_q - N'(1))))) set_d = hit2_q;
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      x1_q      <= '0;
      y1_q      <= '0;
      de1_q     <= 1'b0;
      win1_q    <= 1'b0;
      lose1_q   <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        bx_q[i]   <= '0;
        by_q[i]   <= '0;
        brgb_q[i] <= '0;
      end
      ben_q     <= '0;
      hit2_q    <= '0;
      border2_q <= 1'b0;
      de2_q     <= 1'b0;
      win2_q    <= 1'b0;
      lose2_q   <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      coll_q    <= '0;
    end else begin
      x1_q    <= bus.xCount;
      y1_q    <= bus.yCount;
      de1_q   <= bus.displayArea;
      win1_q  <= bus.win;
      lose1_q <= bus.lose;

      if (bus.frame_start) begin
        for (int i = 0; i < int'(N); i++) begin
          bx_q[i]   <= bus.sprite_x[10*i +: 10];
          by_q[i]   <= bus.sprite_y[9*i +: 9];
          brgb_q[i] <= bus.sprite_rgb[3*i +: 3];
        end
        ben_q <= bus.sprite_en;
      end

      hit2_q    <= hit_d;
      border2_q <= border_d;
      de2_q     <= de1_q;
      win2_q    <= win1_q;
      lose2_q   <= lose1_q;

      r_q <= {8{pix_d[2]}};
      g_q <= {8{pix_d[1]}};
      b_q <= {8{pix_d[0]}};

      // Publish includes this cycle's overlaps so none fall between frames
      if (bus.frame_start) begin
        coll_q <= acc_q | set_d;
        acc_q  <= '0;
      end else begin
        acc_q  <= acc_q | set_d;
      end
    end
  end

  assign bus.VGA_R     = r_q;
  assign bus.VGA_G     = g_q;
  assign bus.VGA_B     = b_q;
  assign bus.collision = coll_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_compositor
// Description : Self-checking bench for sprite_compositor. A frame-level
//               model predicts every output pixel and the collision flags;
//               directed probes pin specific pixels to literal colours.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor;

  localparam int         NS   = 8;
  localparam int         SW   = 10;
  localparam int         SH   = 10;
  localparam int         BD   = 11;
  localparam logic [2:0] BRGB = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  sprite_compositor_if #(.NUM_SPRITES(NS)) bus ();

  sprite_compositor #(
    .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH),
    .BORDER(BD), .BORDER_RGB(BRGB)
  ) dut (
    .VGA_clk(clk),
    .reset  (rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  int         mx   [NS];
  int         my   [NS];
  bit         men  [NS];
  bit [2:0]   mrgb [NS];
  bit [7:0]   macc, mcoll, s0, s1, scur;
  bit [2:0]   p0, p1, out_exp;

  function automatic bit in_sprite(int i, int x, int y);
    return men[i] && (x > mx[i]) && (x < mx[i] + SW) && (y > my[i]) && (y < my[i] + SH);
  endfunction

  function automatic bit [2:0] colour(int x, int y, bit de, bit w, bit l);
    bit [2:0] c = 3'b000;
    bit found = 1'b0;
    if (de) begin
      for (int i = 0; i < NS; i++)
        if (!found && in_sprite(i, x, y)) begin c = mrgb[i]; found = 1'b1; end
      if (!found && (x < BD || x >= 640 - BD || y < BD || y >= 480 - BD)) c = BRGB;
    end
    c[2] = c[2] | l;
    c[1] = c[1] | w;
    return c;
  endfunction

  function automatic bit [7:0] overlaps(int x, int y, bit de);
    bit [7:0] v = 8'h00;
    int n = 0;
    for (int i = 0; i < NS; i++)
      if (in_sprite(i, x, y)) begin v[i] = 1'b1; n++; end
    return (de && n >= 2) ? v : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin mx[i] = 0; my[i] = 0; men[i] = 0; mrgb[i] = 0; end
      macc = 0; mcoll = 0; p0 = 0; p1 = 0; s0 = 0; s1 = 0; out_exp = 0;
      chk_en = 1'b1;
    end else begin
      out_exp = p1;
      scur    = s1;
      if (bus.frame_start) begin
        for (int i = 0; i < NS; i++) begin
          mx[i]   = int'(bus.sprite_x[10*i +: 10]);
          my[i]   = int'(bus.sprite_y[9*i +: 9]);
          men[i]  = bus.sprite_en[i];
          mrgb[i] = bus.sprite_rgb[3*i +: 3];
        end
        mcoll = macc | scur;
        macc  = 0;
      end else begin
        macc = macc | scur;
      end
      p1 = p0;
      s1 = s0;
      p0 = colour(int'(bus.xCount), int'(bus.yCount), bus.displayArea, bus.win, bus.lose);
      s0 = overlaps(int'(bus.xCount), int'(bus.yCount), bus.displayArea);
    end
    #1;
    if (chk_en) begin
      total++;
      if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== {{8{out_exp[2]}}, {8{out_exp[1]}}, {8{out_exp[0]}}}) begin
        bad++;
        $display("FAIL model_pixel t=%0t got R=%h G=%h B=%h want rgb=%b", $time,
                 bus.VGA_R, bus.VGA_G, bus.VGA_B, out_exp);
      end
      total++;
      if (bus.collision !== mcoll) begin
        bad++;
        $display("FAIL model_collision t=%0t got %b want %b", $time, bus.collision, mcoll);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic px(input int x, input int y, input bit de);
    bus.xCount      = 10'(x);
    bus.yCount      = 10'(y);
    bus.displayArea = de;
    @(negedge clk);
  endtask

  // Hold one pixel and check the colour it produces 3 edges later
  task automatic probe(input string nm, input int x, input int y, input bit de, input logic [23:0] want);
    bus.xCount      = 10'(x);
    bus.yCount      = 10'(y);
    bus.displayArea = de;
    repeat (3) @(posedge clk);
    #2;
    lit(nm, {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'h00, want});
    @(negedge clk);
  endtask

  task automatic row(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) px(x, y, 1'b1);
  endtask

  task automatic frame(input int pulses);
    repeat (3) px(700, 500, 1'b0);
    for (int k = 0; k < pulses; k++) begin
      bus.frame_start = 1'b1;
      px(700, 500, 1'b0);
    end
    bus.frame_start = 1'b0;
    repeat (3) px(700, 500, 1'b0);
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input logic [2:0] c, input bit en);
    bus.sprite_x[10*i +: 10] = 10'(x);
    bus.sprite_y[9*i +: 9]   = 9'(y);
    bus.sprite_rgb[3*i +: 3] = c;
    bus.sprite_en[i]         = en;
  endtask

  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] BLACK = 24'h000000;

  initial begin
    bus.xCount = '0; bus.yCount = '0; bus.displayArea = 1'b0; bus.frame_start = 1'b0;
    bus.sprite_x = '0; bus.sprite_y = '0; bus.sprite_en = '0; bus.sprite_rgb = '0;
    bus.win = 1'b0; bus.lose = 1'b0;

    // Reset held for 2 cycles with win asserted mid-line
    @(negedge clk);
    bus.xCount = 10'd300; bus.yCount = 10'd100; bus.displayArea = 1'b1; bus.win = 1'b1;
    @(posedge clk); #2;
    lit("reset_rgb", {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    probe("win_after_reset", 320, 240, 1'b1, GREEN);
    lit("reset_collision", {24'h0, bus.collision}, 32'h0);
    bus.win = 1'b0;

    // Single sprite
    set_sprite(0, 100, 200, 3'b100, 1'b1);
    frame(1);
    row(205, 95, 115);
    probe("single_x101", 101, 205, 1'b1, RED);
    probe("single_x109", 109, 205, 1'b1, RED);
    probe("single_x100", 100, 205, 1'b1, BLACK);
    probe("single_x110", 110, 205, 1'b1, BLACK);
    row(200, 95, 115);
    probe("single_y200", 105, 200, 1'b1, BLACK);

    // Priority: sprite 2 green over sprite 5 red
    set_sprite(0, 100, 200, 3'b100, 1'b0);
    set_sprite(2, 100, 200, 3'b010, 1'b1);
    set_sprite(5, 105, 200, 3'b100, 1'b1);
    frame(1);
    row(205, 95, 120);
    probe("prio_x103", 103, 205, 1'b1, GREEN);
    probe("prio_x107", 107, 205, 1'b1, GREEN);
    probe("prio_x112", 112, 205, 1'b1, RED);
    probe("prio_x115", 115, 205, 1'b1, BLACK);

    // Collision flags
    frame(1);
    lit("coll_overlap", {24'h0, bus.collision}, 32'h24);
    row(205, 95, 120);
    set_sprite(5, 300, 300, 3'b100, 1'b1);
    frame(1);
    lit("coll_second", {24'h0, bus.collision}, 32'h24);
    row(205, 95, 120);
    frame(1);
    lit("coll_clear", {24'h0, bus.collision}, 32'h0);

    // Frame sync: a mid-frame port change waits for frame_start
    probe("sync_before", 105, 205, 1'b1, GREEN);
    set_sprite(2, 300, 200, 3'b010, 1'b1);
    probe("sync_hold", 105, 205, 1'b1, GREEN);
    probe("sync_not_yet", 305, 205, 1'b1, BLACK);
    frame(1);
    probe("sync_old_gone", 105, 205, 1'b1, BLACK);
    probe("sync_new", 305, 205, 1'b1, GREEN);
    probe("gated_sprite", 305, 205, 1'b0, BLACK);

    // Border edges
    probe("border_left", 5, 240, 1'b1, BLUE);
    probe("centre_black", 320, 240, 1'b1, BLACK);
    probe("border_right", 629, 240, 1'b1, BLUE);
    probe("inside_right", 628, 240, 1'b1, BLACK);
    probe("border_top", 320, 10, 1'b1, BLUE);
    probe("inside_top", 320, 11, 1'b1, BLACK);
    probe("border_bottom", 320, 469, 1'b1, BLUE);
    probe("inside_bottom", 320, 468, 1'b1, BLACK);

    // win/lose overrides
    bus.lose = 1'b1;
    probe("lose_blank", 320, 240, 1'b0, RED);
    bus.win = 1'b1;
    probe("win_lose", 320, 240, 1'b1, 24'hFFFF00);
    probe("win_lose_border", 5, 240, 1'b1, 24'hFFFFFF);
    bus.win = 1'b0; bus.lose = 1'b0;

    // Back-to-back frame_start: second pulse publishes nothing new
    set_sprite(5, 305, 200, 3'b100, 1'b1);
    frame(1);
    row(205, 295, 320);
    frame(2);
    lit("coll_double_pulse", {24'h0, bus.collision}, 32'h0);
    row(205, 295, 320);
    frame(1);
    lit("coll_again", {24'h0, bus.collision}, 32'h24);

    // Reset mid-frame clears bank and flags
    row(205, 295, 300);
    rst = 1'b1;
    px(302, 205, 1'b1);
    rst = 1'b0;
    row(205, 303, 312);
    lit("midreset_collision", {24'h0, bus.collision}, 32'h0);
    probe("midreset_no_sprite", 307, 205, 1'b1, BLACK);
    probe("midreset_border", 5, 240, 1'b1, BLUE);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
